// File: rtl/rtc_count_latch_if.sv
// Control and result bundle between the trigger-detection stage and the
// stopwatch counting stage.
interface rtc_count_latch_if #(
   parameter int WIDTH = 24
);
   logic             i_countinit;
   logic             i_countenb;
   logic             i_latchcount;
   logic [WIDTH-1:0] o_count;
   logic [WIDTH-1:0] o_latched;
   logic             o_latch_valid;
   logic             o_overflow;
   logic [1:0]       o_state;

   modport master (
      output i_countinit, i_countenb, i_latchcount,
      input  o_count, o_latched, o_latch_valid, o_overflow, o_state
   );

   modport slave (
      input  i_countinit, i_countenb, i_latchcount,
      output o_count, o_latched, o_latch_valid, o_overflow, o_state
   );
endinterface

// File: rtl/rtc_count_latch.sv
// Stopwatch counting stage: prescaled elapsed-time counter, edge-triggered
// snapshot register, run-state FSM and sticky overflow flag.
module rtc_count_latch #(
   parameter int WIDTH    = 24,
   parameter int TICK_DIV = 1000
) (
   input logic              i_sclk,
   input logic              i_reset_n,
   rtc_count_latch_if.slave bus
);
   localparam logic [15:0]      PRE_TERM = 16'(TICK_DIV - 1);
   localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

   typedef enum logic [1:0] {
      ST_CLEARED = 2'b00,
      ST_RUNNING = 2'b01,
      ST_PAUSED  = 2'b10
   } state_t;

   state_t           state_r, state_nxt_s;
   logic [WIDTH-1:0] count_r, count_nxt_s;
   logic [WIDTH-1:0] latched_r, latched_nxt_s;
   logic [15:0]      pre_r, pre_nxt_s;
   logic             ovf_r, ovf_nxt_s;
   logic             valid_r;
   logic             latch_ref_r;
   logic             latch_req_s;

   // Either edge of the latch input counts as one request.
   assign latch_req_s = bus.i_latchcount ^ latch_ref_r;

   // Datapath next state: capture from the pre-update count, then clear, then increment.
   always_comb begin
      latched_nxt_s = latched_r;
      count_nxt_s   = count_r;
      pre_nxt_s     = pre_r;
      ovf_nxt_s     = ovf_r;
      if (latch_req_s) begin
         latched_nxt_s = count_r;
      end else begin
         latched_nxt_s = latched_r;
      end
      if (bus.i_countinit) begin
         count_nxt_s = {WIDTH{1'b0}};
         pre_nxt_s   = 16'd0;
         ovf_nxt_s   = 1'b0;
      end else if (bus.i_countenb) begin
         if (pre_r == PRE_TERM) begin
            pre_nxt_s   = 16'd0;
            count_nxt_s = count_r + CNT_ONE;
            if (count_r == CNT_MAX) begin
               ovf_nxt_s = 1'b1;
            end else begin
               ovf_nxt_s = ovf_r;
            end
         end else begin
            pre_nxt_s = pre_r + 16'd1;
         end
      end else begin
         // Prescaler holds so the sub-tick phase survives a pause.
         count_nxt_s = count_r;
         pre_nxt_s   = pre_r;
      end
   end

   // Run-state transitions; clear overrides everything, 2'b11 recovers to CLEARED.
   always_comb begin
      state_nxt_s = ST_CLEARED;
      if (bus.i_countinit) begin
         state_nxt_s = ST_CLEARED;
      end else begin
         case (state_r)
            ST_CLEARED: state_nxt_s = bus.i_countenb ? ST_RUNNING : ST_CLEARED;
            ST_RUNNING: state_nxt_s = bus.i_countenb ? ST_RUNNING : ST_PAUSED;
            ST_PAUSED:  state_nxt_s = bus.i_countenb ? ST_RUNNING : ST_PAUSED;
            default:    state_nxt_s = ST_CLEARED;
         endcase
      end
   end

   // Run-state register.
   always_ff @(posedge i_sclk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_r <= ST_CLEARED;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Counter, prescaler, snapshot and flag registers.
   always_ff @(posedge i_sclk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         count_r     <= {WIDTH{1'b0}};
         latched_r   <= {WIDTH{1'b0}};
         pre_r       <= 16'd0;
         ovf_r       <= 1'b0;
         valid_r     <= 1'b0;
         latch_ref_r <= 1'b0;
      end else begin
         count_r     <= count_nxt_s;
         latched_r   <= latched_nxt_s;
         pre_r       <= pre_nxt_s;
         ovf_r       <= ovf_nxt_s;
         valid_r     <= latch_req_s;
         latch_ref_r <= bus.i_latchcount;
      end
   end

   assign bus.o_count       = count_r;
   assign bus.o_latched     = latched_r;
   assign bus.o_latch_valid = valid_r;
   assign bus.o_overflow    = ovf_r;
   assign bus.o_state       = state_r;
endmodule

// File: tb/tb_rtc_count_latch.sv
// Directed bench: unit A (WIDTH 24, TICK_DIV 4) for run/pause/latch/clear,
// unit B (WIDTH 8, TICK_DIV 1) for wrap and overflow.
module tb_rtc_count_latch;
   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   rtc_count_latch_if #(.WIDTH(24)) bus_a ();
   rtc_count_latch_if #(.WIDTH(8))  bus_b ();

   rtc_count_latch #(.WIDTH(24), .TICK_DIV(4)) dut_a (
      .i_sclk(clk), .i_reset_n(rst_n), .bus(bus_a.slave)
   );
   rtc_count_latch #(.WIDTH(8), .TICK_DIV(1)) dut_b (
      .i_sclk(clk), .i_reset_n(rst_n), .bus(bus_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      bus_a.i_countinit = 1'b0; bus_a.i_countenb = 1'b0; bus_a.i_latchcount = 1'b0;
      bus_b.i_countinit = 1'b0; bus_b.i_countenb = 1'b0; bus_b.i_latchcount = 1'b0;
      #2;
      // 1. Reset state, then clear and idle
      check("rst_count",   32'(bus_a.o_count), 32'd0);
      check("rst_latched", 32'(bus_a.o_latched), 32'd0);
      check("rst_valid",   32'(bus_a.o_latch_valid), 32'd0);
      check("rst_ovf",     32'(bus_a.o_overflow), 32'd0);
      check("rst_state",   32'(bus_a.o_state), 32'd0);
      #5;
      rst_n = 1'b1;
      tick();
      bus_a.i_countinit = 1'b1;
      tick();
      bus_a.i_countinit = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("idle_valid", 32'(bus_a.o_latch_valid), 32'd0);
         check("idle_count", 32'(bus_a.o_count), 32'd0);
      end
      check("idle_state", 32'(bus_a.o_state), 32'd0);
      check("idle_ovf",   32'(bus_a.o_overflow), 32'd0);

      // 2. Run 40 cycles: one increment every 4th enabled cycle
      bus_a.i_countenb = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         check("run_count", 32'(bus_a.o_count), 32'(k / 4));
      end
      check("run_state", 32'(bus_a.o_state), 32'd1);
      check("run_final", 32'(bus_a.o_count), 32'd10);

      // 3. Pause after count 1 / prescaler 2, resume
      bus_a.i_countinit = 1'b1;
      bus_a.i_countenb  = 1'b0;
      tick();
      bus_a.i_countinit = 1'b0;
      check("clr_count", 32'(bus_a.o_count), 32'd0);
      check("clr_state", 32'(bus_a.o_state), 32'd0);
      bus_a.i_countenb = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      check("pre_pause_count", 32'(bus_a.o_count), 32'd1);
      bus_a.i_countenb = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("pause_state", 32'(bus_a.o_state), 32'd2);
         check("pause_count", 32'(bus_a.o_count), 32'd1);
      end
      bus_a.i_countenb = 1'b1;
      tick();
      check("resume1_count", 32'(bus_a.o_count), 32'd1);
      check("resume_state",  32'(bus_a.o_state), 32'd1);
      tick();
      check("resume2_count", 32'(bus_a.o_count), 32'd2);

      // 4. Two latch toggles on consecutive cycles, at count 7 / prescaler 3
      for (int i = 0; i < 23; i++) tick();
      check("pre_latch_count", 32'(bus_a.o_count), 32'd7);
      bus_a.i_latchcount = 1'b1;
      tick();
      check("latch1_valid", 32'(bus_a.o_latch_valid), 32'd1);
      check("latch1_value", 32'(bus_a.o_latched), 32'd7);
      check("latch1_count", 32'(bus_a.o_count), 32'd8);
      bus_a.i_latchcount = 1'b0;
      tick();
      check("latch2_valid", 32'(bus_a.o_latch_valid), 32'd1);
      check("latch2_value", 32'(bus_a.o_latched), 32'd8);
      tick();
      check("latch_end_valid", 32'(bus_a.o_latch_valid), 32'd0);
      check("latch_hold",      32'(bus_a.o_latched), 32'd8);

      // 5. Overflow on the 8-bit, divide-by-1 unit
      bus_b.i_countenb = 1'b1;
      for (int i = 0; i < 255; i++) tick();
      check("ovf_pre_count", 32'(bus_b.o_count), 32'd255);
      check("ovf_pre_flag",  32'(bus_b.o_overflow), 32'd0);
      tick();
      check("ovf_wrap_count", 32'(bus_b.o_count), 32'd0);
      check("ovf_wrap_flag",  32'(bus_b.o_overflow), 32'd1);
      tick();
      tick();
      check("ovf_held_count", 32'(bus_b.o_count), 32'd2);
      check("ovf_held_flag",  32'(bus_b.o_overflow), 32'd1);
      bus_b.i_countinit = 1'b1;
      tick();
      bus_b.i_countinit = 1'b0;
      bus_b.i_countenb  = 1'b0;
      check("ovf_clr_flag",  32'(bus_b.o_overflow), 32'd0);
      check("ovf_clr_state", 32'(bus_b.o_state), 32'd0);
      check("ovf_clr_count", 32'(bus_b.o_count), 32'd0);

      // 6. Latch together with clear at count 42, then reset mid-run
      bus_a.i_countinit = 1'b1;
      tick();
      bus_a.i_countinit = 1'b0;
      for (int i = 0; i < 168; i++) tick();
      check("pre_sim_count", 32'(bus_a.o_count), 32'd42);
      bus_a.i_latchcount = 1'b1;
      bus_a.i_countinit  = 1'b1;
      tick();
      bus_a.i_countinit = 1'b0;
      check("sim_latched", 32'(bus_a.o_latched), 32'd42);
      check("sim_valid",   32'(bus_a.o_latch_valid), 32'd1);
      check("sim_count",   32'(bus_a.o_count), 32'd0);
      check("sim_state",   32'(bus_a.o_state), 32'd0);
      for (int i = 0; i < 8; i++) tick();
      check("prerst_count", 32'(bus_a.o_count), 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_count",   32'(bus_a.o_count), 32'd0);
      check("midrst_latched", 32'(bus_a.o_latched), 32'd0);
      check("midrst_valid",   32'(bus_a.o_latch_valid), 32'd0);
      check("midrst_ovf",     32'(bus_a.o_overflow), 32'd0);
      check("midrst_state",   32'(bus_a.o_state), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/rtc_count_latch.md
# rtc_count_latch

Downstream counting stage of the stopwatch trigger path. Consumes the init/enable/latch controls produced by the trigger-detection stage. Runs a prescaled elapsed-time counter and captures a stable snapshot of it for the display path on every latch request. Also reports run state and a sticky overflow flag.

## Interface

**Parameters**
- `WIDTH`, 24: counter and snapshot width in bits.
- `TICK_DIV`, 1000: `i_sclk` cycles per count increment. Legal range is 1 to 2^16.

**Ports** (name, direction, width, meaning)
- `i_sclk`, in, 1: the only clock. All logic is on its rising edge.
- `i_reset_n`, in, 1: asynchronous, active-low reset.
- `i_countinit`, in, 1: synchronous clear request, active high.
- `i_countenb`, in, 1: run enable, level sensitive.
- `i_latchcount`, in, 1: latch request. Every transition, rising or falling, is one request.
- `o_count`, out, `WIDTH`: live counter value.
- `o_latched`, out, `WIDTH`: snapshot register.
- `o_latch_valid`, out, 1: one-cycle pulse when `o_latched` has just been updated.
- `o_overflow`, out, 1: sticky flag, set when the counter wraps.
- `o_state`, out, 2: run state. 2'b00 = CLEARED, 2'b01 = RUNNING, 2'b10 = PAUSED.

## Operation

**Reset (asynchronous, while `i_reset_n` = 0)**
- `o_count` = 0, `o_latched` = 0, `o_latch_valid` = 0, `o_overflow` = 0, `o_state` = CLEARED.
- The prescaler is 0 and the latch-edge reference register is 0.

**Priority each cycle**
- The latch capture is evaluated first, against the pre-update counter value.
- `i_countinit` comes next.
- The enable/increment logic comes last.

**Clear (`i_countinit` = 1)**
- Next cycle: `o_count` = 0, prescaler = 0, `o_overflow` = 0, `o_state` = CLEARED.
- Any increment due in that cycle is discarded.
- `o_latched` is not cleared.

**Prescaler**
- When `i_countenb` = 1 and no clear is active, the prescaler counts 0 … `TICK_DIV`-1.
- At terminal value `TICK_DIV`-1, the prescaler returns to 0 and the counter increments.
- When `i_countenb` = 0, the prescaler holds its value, so the sub-tick phase is preserved across a pause.
- With `TICK_DIV` = 1, the counter increments on every enabled cycle.

**Counter arithmetic**
- Unsigned, modulo 2^`WIDTH`.
- An increment from 2^`WIDTH`-1 gives 0 and sets `o_overflow` in the same update.
- `o_overflow` stays set until a clear or reset.

**Latch**
- A request is detected when `i_latchcount` differs from its registered copy.
- The registered copy updates every cycle.
- Next cycle: `o_latched` = the `o_count` value of the detection cycle, and `o_latch_valid` = 1 for exactly one cycle.
- Requests on consecutive cycles each produce a capture and a pulse.
- A request in the same cycle as `i_countinit` captures the pre-clear value.

**State machine (registered)**

| Current state | Condition | Next state |
|---|---|---|
| any | `i_countinit` | CLEARED |
| CLEARED | `i_countenb` = 1 | RUNNING |
| RUNNING | `i_countenb` = 0 | PAUSED |
| PAUSED | `i_countenb` = 1 | RUNNING |
| CLEARED | `i_countenb` = 0 | stays CLEARED |

- PAUSED never returns to CLEARED without `i_countinit`.
- The encoding 2'b11 is unreachable. If it is ever reached, it recovers to CLEARED on the next cycle.

## Timing

- **Increment latency:** in the cycle the prescaler is at `TICK_DIV`-1 with enable high, `o_count` updates at the following rising edge.
- **Enable latency:** from `i_countenb` rising, the first increment is `TICK_DIV` cycles later when starting from a zero prescaler.
- **Latch latency:** the `i_latchcount` transition is sampled at edge N, and `o_latched` and `o_latch_valid` are valid after edge N+1.
- **Clear latency:** effective after the edge that samples `i_countinit`.
- **Outputs:** all are registered, with no combinational input-to-output paths.
- **Reset deassertion:** the first sampling edge treats the latch reference as 0. An `i_latchcount` already at 1 therefore produces one capture.
- **Reset mid-run:** all state is lost immediately, with no pending pulse.

## Test plan

1. **Reset then clear.** Setup: reset, `i_countinit`=1 for 1 cycle, then `i_countenb`=0 for 20 cycles. Required: all outputs 0, `o_state`=00, no `o_latch_valid` pulse.
2. **Run.** Setup: `TICK_DIV`=4, `i_countenb`=1 for 40 cycles. Required: `o_count` reaches 10, one increment every 4th cycle, `o_state`=01.
3. **Pause and resume.** Setup: `TICK_DIV`=4. Drop enable after 6 enabled cycles (count 1, prescaler 2), hold low 10 cycles, then re-enable. Required: `o_state`=10 while low, count holds at 1, and it reaches 2 exactly 2 enabled cycles after resume.
4. **Latch.** Setup: toggle `i_latchcount` at count 7, then again one cycle later. Required: two `o_latch_valid` pulses on consecutive cycles, and `o_latched` is 7, then the value of the next cycle.
5. **Overflow.** Setup: `WIDTH`=8, `TICK_DIV`=1, run 256 cycles. Required: `o_count` goes 255 → 0, `o_overflow`=1 and held. Then `i_countinit` gives `o_overflow`=0 and `o_state`=00.
6. **Simultaneous latch and clear.** Setup: latch toggle together with `i_countinit` at count 42. Required: `o_latched`=42 with a pulse, `o_count`=0. Follow-up: assert `i_reset_n`=0 mid-run. Required: all outputs 0 immediately.
